// File: rtl/read2control.sv
// read2control: buffer read controller.
// Fetches one line per config from the BRAM bank and streams int8 beats.
module read2control #(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 13,
    parameter int DATA_LEN     = 32,
    parameter int MAX_LINE_LEN = 10,
    parameter int RD_LAT       = 2,
    parameter int BUFFER_NUM   = X_MAC * X_MESH,
    parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN,
    parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      conf_input,
    input  logic [ADDR_LEN*X_MAC-1:0] st_addr,
    input  logic [MAX_LINE_LEN-1:0]   linelen,
    input  logic [1:0]                valid_mac,
    input  logic                      pooled,
    output logic [ADDRWIDTH-1:0]      addrb,
    output logic [BUFFER_NUM-1:0]     enb,
    input  logic [DATAWIDTH-1:0]      doutb,
    output logic [32*X_MESH-1:0]      out_data_4,
    output logic [8*X_MESH-1:0]       out_data_1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      req,
    output logic                      idle
);

    localparam int WW = MAX_LINE_LEN - 2;
    localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
    localparam int MW = DATA_LEN * X_MESH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_LEN*X_MAC-1:0] st_addr_q, st_addr_d;
    logic [MAX_LINE_LEN-1:0]   linelen_q, linelen_d;
    logic [1:0]                vmac_q, vmac_d;
    logic                      pooled_q, pooled_d;
    logic [WW-1:0]             widx_q, widx_d;
    logic [CW-1:0]             lat_q, lat_d;
    logic [1:0]                beat_q, beat_d;
    logic [MW-1:0]             word0_q, word0_d;
    logic [MW-1:0]             word1_q, word1_d;

    logic [MAX_LINE_LEN-1:0]   len_m1;
    logic [WW-1:0]             last_w;
    logic [1:0]                rem_m1;
    logic                      is_last;
    logic [1:0]                beats_m1;
    logic                      last_beat;
    logic [1:0]                m0;
    logic [1:0]                m1;

    // Line geometry: last word index and beats in the current word.
    always_comb begin
        len_m1    = linelen_q - MAX_LINE_LEN'(1);
        last_w    = len_m1[MAX_LINE_LEN-1:2];
        rem_m1    = len_m1[1:0];
        is_last   = (widx_q == last_w);
        m0        = vmac_q;
        m1        = vmac_q + 2'd1;
        beats_m1  = 2'd0;
        if (pooled_q) begin
            beats_m1 = is_last ? rem_m1 : 2'd3;
        end else begin
            beats_m1 = is_last ? {1'b0, rem_m1[1]} : 2'd1;
        end
        last_beat = (beat_q == beats_m1);
    end

    // Next-state logic: config latch, fetch, latency wait, beat emission.
    always_comb begin
        state_d   = state_q;
        st_addr_d = st_addr_q;
        linelen_d = linelen_q;
        vmac_d    = vmac_q;
        pooled_d  = pooled_q;
        widx_d    = widx_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        word0_d   = word0_q;
        word1_d   = word1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (conf_input) begin
                    st_addr_d = st_addr;
                    linelen_d = linelen;
                    vmac_d    = valid_mac;
                    pooled_d  = pooled;
                    widx_d    = '0;
                    if (linelen != '0) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                lat_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                lat_d = lat_q + CW'(1);
                if (lat_q == CW'(RD_LAT - 1)) begin
                    for (int i = 0; i < X_MESH; i++) begin
                        word0_d[i*DATA_LEN +: DATA_LEN] =
                            doutb[(int'(m0) + i*X_MAC)*DATA_LEN +: DATA_LEN];
                        word1_d[i*DATA_LEN +: DATA_LEN] =
                            doutb[(int'(m1) + i*X_MAC)*DATA_LEN +: DATA_LEN];
                    end
                    beat_d  = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (is_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            widx_d  = widx_q + WW'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            st_addr_q <= '0;
            linelen_q <= '0;
            vmac_q    <= '0;
            pooled_q  <= 1'b0;
            widx_q    <= '0;
            lat_q     <= '0;
            beat_q    <= '0;
            word0_q   <= '0;
            word1_q   <= '0;
        end else begin
            state_q   <= state_d;
            st_addr_q <= st_addr_d;
            linelen_q <= linelen_d;
            vmac_q    <= vmac_d;
            pooled_q  <= pooled_d;
            widx_q    <= widx_d;
            lat_q     <= lat_d;
            beat_q    <= beat_d;
            word0_q   <= word0_d;
            word1_q   <= word1_d;
        end
    end

    // BRAM read port: one-cycle enable on active columns in every mesh row.
    always_comb begin
        enb   = '0;
        addrb = '0;
        if (state_q == ST_FETCH) begin
            for (int i = 0; i < X_MESH; i++) begin
                enb[int'(m0) + i*X_MAC] = 1'b1;
                if (!pooled_q) begin
                    enb[int'(m1) + i*X_MAC] = 1'b1;
                end
            end
            for (int b = 0; b < BUFFER_NUM; b++) begin
                addrb[b*ADDR_LEN +: ADDR_LEN] =
                    st_addr_q[(b % X_MAC)*ADDR_LEN +: ADDR_LEN]
                    + ADDR_LEN'(widx_q);
            end
        end
    end

    // Beat unpacking from the word registers; inactive bus held at zero.
    always_comb begin
        out_data_1 = '0;
        out_data_4 = '0;
        if (state_q == ST_EMIT) begin
            for (int i = 0; i < X_MESH; i++) begin
                if (pooled_q) begin
                    out_data_1[i*8 +: 8] =
                        word0_q[i*DATA_LEN + int'(beat_q)*8 +: 8];
                end else begin
                    out_data_4[i*32 +: 16] =
                        word0_q[i*DATA_LEN + int'(beat_q[0])*16 +: 16];
                    out_data_4[i*32 + 16 +: 16] =
                        word1_q[i*DATA_LEN + int'(beat_q[0])*16 +: 16];
                end
            end
        end
    end

    assign out_valid = (state_q == ST_EMIT);
    assign req       = (state_q != ST_IDLE);
    assign idle      = !req && (state_q == ST_IDLE);

endmodule

// File: tb/tb_read2control.sv
// tb_read2control: randomized bench for read2control.
// BRAM model plus element-level reference of each line's beat stream.
module tb_read2control;

    localparam int X_MAC  = 4;
    localparam int X_MESH = 16;
    localparam int AL     = 13;
    localparam int DL     = 32;
    localparam int ML     = 10;
    localparam int RD_LAT = 2;
    localparam int BN     = X_MAC * X_MESH;

    typedef struct packed {
        logic [8*X_MESH-1:0]  d1;
        logic [32*X_MESH-1:0] d4;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   conf_input;
    logic [AL*X_MAC-1:0]    st_addr;
    logic [ML-1:0]          linelen;
    logic [1:0]             valid_mac;
    logic                   pooled;
    logic [BN*AL-1:0]       addrb;
    logic [BN-1:0]          enb;
    logic [BN*DL-1:0]       doutb;
    logic [32*X_MESH-1:0]   out_data_4;
    logic [8*X_MESH-1:0]    out_data_1;
    logic                   out_valid;
    logic                   out_ready;
    logic                   req;
    logic                   idle;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [BN][8192];
    logic [31:0] pipe [RD_LAT][BN];

    always #5 clk = ~clk;

    read2control #(
        .X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(AL), .DATA_LEN(DL),
        .MAX_LINE_LEN(ML), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .conf_input(conf_input), .st_addr(st_addr),
        .linelen(linelen), .valid_mac(valid_mac), .pooled(pooled),
        .addrb(addrb), .enb(enb), .doutb(doutb),
        .out_data_4(out_data_4), .out_data_1(out_data_1),
        .out_valid(out_valid), .out_ready(out_ready),
        .req(req), .idle(idle)
    );

    always @(posedge clk) begin
        for (int b = 0; b < BN; b++) begin
            if (enb[b]) pipe[0][b] <= mem[b][addrb[b*AL +: AL]];
            for (int k = 1; k < RD_LAT; k++) pipe[k][b] <= pipe[k-1][b];
        end
    end

    for (genvar g = 0; g < BN; g++) begin : g_dout
        assign doutb[g*DL +: DL] = pipe[RD_LAT-1][g];
    end

    function automatic int lane(input logic [AL*X_MAC-1:0] st, input int j);
        return int'(st[j*AL +: AL]);
    endfunction

    function automatic logic [AL*X_MAC-1:0] rand_st();
        logic [AL*X_MAC-1:0] s;
        for (int j = 0; j < X_MAC; j++) s[j*AL +: AL] = AL'($urandom);
        return s;
    endfunction

    task automatic run_line(
        input bit pd, input int len, input int vm,
        input logic [AL*X_MAC-1:0] st, input int rmode, input bit inject,
        output logic [8*X_MESH-1:0] f1, output logic [8*X_MESH-1:0] l1,
        output logic [32*X_MESH-1:0] f4, output int nb);
        beat_t q[$];
        beat_t bt;
        int n, nw, c, popped, nwords, end_c, col;
        bit seen, aok;
        logic [31:0] wd;
        logic [BN-1:0] em;
        int pat[4];
        pat = '{1, 0, 0, 1};
        n  = pd ? len : (len + 1) / 2;
        nw = (len + 3) / 4;
        for (int e = 0; e < n; e++) begin
            bt = '0;
            for (int i = 0; i < X_MESH; i++) begin
                if (pd) begin
                    wd = mem[i*X_MAC + vm][(lane(st, vm) + e/4) % 8192];
                    bt.d1[i*8 +: 8] = wd[(e%4)*8 +: 8];
                end else begin
                    for (int r = 0; r < 2; r++) begin
                        col = (vm + r) % 4;
                        wd = mem[i*X_MAC + col][(lane(st, col) + e/2) % 8192];
                        for (int k = 0; k < 2; k++)
                            bt.d4[(k + 2*r + 4*i)*8 +: 8] = wd[(2*(e%2) + k)*8 +: 8];
                    end
                end
            end
            q.push_back(bt);
        end
        em = '0;
        for (int i = 0; i < X_MESH; i++) begin
            em[i*X_MAC + vm] = 1'b1;
            if (!pd) em[i*X_MAC + (vm + 1) % 4] = 1'b1;
        end
        f1 = '0; l1 = '0; f4 = '0; nb = 0;
        popped = 0; nwords = 0; seen = 0;
        end_c = (n == 0) ? 1 : -1;
        c = 0;
        @(posedge clk); #1;
        conf_input = 1'b1; pooled = pd; linelen = ML'(len);
        valid_mac = 2'(vm); st_addr = st;
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom % 3 != 0) : pat[0][0];
        while (1) begin
            @(negedge clk);
            if (enb !== '0) begin
                checks++;
                if (nwords >= nw || enb !== em) begin
                    failures++;
                    $display("FAIL enb_mask c=%0d word=%0d got=%h want=%h", c, nwords, enb, em);
                end
                aok = 1;
                for (int b = 0; b < BN; b++)
                    if (addrb[b*AL +: AL] !== AL'(lane(st, b % 4) + nwords)) aok = 0;
                checks++;
                if (!aok) begin
                    failures++;
                    $display("FAIL addrb c=%0d word=%0d got=%0d want=%0d", c, nwords,
                             addrb[vm*AL +: AL], AL'(lane(st, vm) + nwords));
                end
                checks++;
                if (popped != (pd ? 4*nwords : 2*nwords) || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_order c=%0d word=%0d popped=%0d valid=%b", c, nwords, popped, out_valid);
                end
                nwords++;
            end
            if (out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1;
                    checks++;
                    if (c != 2 + RD_LAT) begin
                        failures++;
                        $display("FAIL first_valid got_cycle=%0d want=%0d", c, 2 + RD_LAT);
                    end
                end
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat c=%0d d1=%h", c, out_data_1);
                end else begin
                    if (out_data_1 !== q[0].d1 || out_data_4 !== q[0].d4) begin
                        failures++;
                        $display("FAIL beat_data idx=%0d d1 got=%h want=%h d4 got=%h want=%h",
                                 popped, out_data_1, q[0].d1, out_data_4, q[0].d4);
                    end
                    if (out_ready) begin
                        if (popped == 0) begin f1 = out_data_1; f4 = out_data_4; end
                        l1 = out_data_1;
                        void'(q.pop_front());
                        popped++;
                        if (popped == n) end_c = c + 1;
                    end
                end
            end
            if (c == end_c) begin
                checks++;
                if (req !== 1'b0 || idle !== 1'b1 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL line_end c=%0d req=%b idle=%b valid=%b want 0 1 0", c, req, idle, out_valid);
                end
            end else if (c >= 1 && end_c < 0) begin
                checks++;
                if (req !== 1'b1 || idle !== 1'b0) begin
                    failures++;
                    $display("FAIL req_active c=%0d req=%b idle=%b want 1 0", c, req, idle);
                end
            end
            if (end_c >= 0 && c >= end_c + 3) break;
            if (c >= 4000) begin
                checks++; failures++;
                $display("FAIL timeout popped=%0d want=%0d", popped, n);
                break;
            end
            @(posedge clk); #1;
            c++;
            conf_input = 1'b0;
            if (inject && len != 0 && c == 3) begin
                conf_input = 1'b1;
                linelen = ML'($urandom_range(1, 40));
                valid_mac = ~2'(vm); pooled = ~pd; st_addr = rand_st();
            end
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom % 3 != 0) : pat[c%4][0];
        end
        conf_input = 1'b0;
        checks++;
        if (popped != n || nwords != nw) begin
            failures++;
            $display("FAIL beat_count beats=%0d want=%0d words=%0d want=%0d", popped, n, nwords, nw);
        end
        nb = popped;
    endtask

    task automatic test_reset;
        rst = 1'b1; conf_input = 1'b0; out_ready = 1'b0;
        st_addr = '0; linelen = '0; valid_mac = '0; pooled = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (addrb !== '0 || enb !== '0) begin
            failures++; $display("FAIL reset_bram enb=%h want=0", enb);
        end
        checks++;
        if (out_data_4 !== '0 || out_data_1 !== '0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_data valid=%b d1=%h want 0", out_valid, out_data_1);
        end
        checks++;
        if (req !== 1'b0 || idle !== 1'b1) begin
            failures++; $display("FAIL reset_status req=%b idle=%b want 0 1", req, idle);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_mode_a;
        logic [AL*X_MAC-1:0] st;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        st = rand_st(); st[2*AL +: AL] = 13'd10;
        mem[2][10] = 32'h44332211; mem[2][11] = 32'hA5A56655;
        run_line(1'b1, 6, 2, st, 0, 1'b0, f1, l1, f4, nb);
        checks++;
        if (f1[7:0] !== 8'h11 || l1[7:0] !== 8'h66 || nb != 6) begin
            failures++;
            $display("FAIL mode_a_bytes first=%h last=%h beats=%0d want 11 66 6", f1[7:0], l1[7:0], nb);
        end
        checks++;
        if (f4 !== '0) begin
            failures++; $display("FAIL mode_a_unused d4=%h want 0", f4);
        end
    endtask

    task automatic test_mode_b;
        logic [AL*X_MAC-1:0] st;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        st = rand_st(); st[3*AL +: AL] = 13'd5; st[0 +: AL] = 13'd20;
        mem[3][5] = 32'hDDCC2211; mem[0][20] = 32'hFFEE4433;
        run_line(1'b0, 8, 3, st, 0, 1'b0, f1, l1, f4, nb);
        checks++;
        if (f4[31:0] !== 32'h44332211 || nb != 4 || f1 !== '0) begin
            failures++;
            $display("FAIL mode_b_window got=%h beats=%0d want=44332211 4", f4[31:0], nb);
        end
    endtask

    task automatic test_mode_b_short;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        run_line(1'b0, 3, 1, rand_st(), 0, 1'b0, f1, l1, f4, nb);
        checks++;
        if (nb != 2) begin
            failures++; $display("FAIL mode_b_short beats=%0d want=2", nb);
        end
    endtask

    task automatic test_backpressure;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        run_line(1'b1, 11, 0, rand_st(), 2, 1'b0, f1, l1, f4, nb);
        run_line(1'b0, 13, 2, rand_st(), 2, 1'b0, f1, l1, f4, nb);
    endtask

    task automatic test_zero_len;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        run_line(1'b1, 0, 1, rand_st(), 0, 1'b0, f1, l1, f4, nb);
    endtask

    task automatic test_reset_mid;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        @(posedge clk); #1;
        conf_input = 1'b1; pooled = 1'b0; linelen = 10'd40;
        valid_mac = 2'd1; st_addr = rand_st(); out_ready = 1'b1;
        @(posedge clk); #1 conf_input = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (enb !== '0 || addrb !== '0 || out_valid !== 1'b0 ||
            out_data_1 !== '0 || out_data_4 !== '0) begin
            failures++; $display("FAIL reset_mid_outputs enb=%h valid=%b want 0", enb, out_valid);
        end
        checks++;
        if (req !== 1'b0 || idle !== 1'b1) begin
            failures++; $display("FAIL reset_mid_status req=%b idle=%b want 0 1", req, idle);
        end
        run_line(1'b1, 7, 3, rand_st(), 0, 1'b0, f1, l1, f4, nb);
    endtask

    task automatic test_conf_ignored;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        run_line(1'b1, 9, 1, rand_st(), 1, 1'b1, f1, l1, f4, nb);
        run_line(1'b0, 10, 2, rand_st(), 0, 1'b1, f1, l1, f4, nb);
    endtask

    task automatic test_addr_wrap;
        logic [AL*X_MAC-1:0] st;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        st = rand_st(); st[1*AL +: AL] = 13'd8190;
        run_line(1'b1, 16, 1, st, 0, 1'b0, f1, l1, f4, nb);
    endtask

    task automatic test_max_len;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        run_line(1'b1, 1023, 0, rand_st(), 0, 1'b0, f1, l1, f4, nb);
    endtask

    task automatic test_back_to_back;
        logic [8*X_MESH-1:0] f1, l1;
        logic [32*X_MESH-1:0] f4;
        int nb;
        for (int t = 0; t < 12; t++)
            run_line(1'($urandom % 2), $urandom_range(1, 24), $urandom_range(0, 3),
                     rand_st(), 1, 1'b0, f1, l1, f4, nb);
    endtask

    initial begin
        for (int b = 0; b < BN; b++)
            for (int a = 0; a < 8192; a++)
                mem[b][a] = $urandom;
        test_reset();
        test_mode_a();
        test_mode_b();
        test_mode_b_short();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_conf_ignored();
        test_addr_wrap();
        test_max_len();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read2control.md
# read2control

Buffer read controller: the read-side counterpart of the output write controller. After a configuration pulse it fetches one feature-map line from the X_MAC×X_MESH BRAM bank, unpacks the 32-bit words into int8 elements and streams them to the compute array over a valid/ready handshake. It supports two layouts:
- single-element (pooled) layout: four bytes per word in one MAC column;
- 2×2-window layout: two 16-bit column pairs per word, split across two adjacent MAC columns.

## Interface
- X_MAC, 4, MAC columns per mesh row.
- X_MESH, 16, mesh rows.
- ADDR_LEN, 13, BRAM address width.
- DATA_LEN, 32, BRAM word width (4 × int8).
- MAX_LINE_LEN, 10, width of `linelen`.
- RD_LAT, 2, BRAM read latency in cycles (≥1).
- BUFFER_NUM, X_MAC*X_MESH; ADDRWIDTH, BUFFER_NUM*ADDR_LEN; DATAWIDTH, BUFFER_NUM*DATA_LEN.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- conf_input  in  1  one-cycle configuration strobe.
- st_addr  in  ADDR_LEN*X_MAC  start address per MAC column; lane j = [j*ADDR_LEN +: ADDR_LEN].
- linelen  in  MAX_LINE_LEN  line length in columns (elements).
- valid_mac  in  2  base MAC column.
- pooled  in  1  1 = single-element layout; 0 = 2×2-window layout.
- addrb  out  ADDRWIDTH  buffer (i,j) at [(j+i*X_MAC)*ADDR_LEN +: ADDR_LEN].
- enb  out  BUFFER_NUM  read enable; buffer (i,j) is bit j+i*X_MAC.
- doutb  in  DATAWIDTH  read data; same indexing as addrb, DATA_LEN per buffer.
- out_data_4  out  32*X_MESH  2×2 window; byte (mesh i, row r, col k) at [(k+2r+4i)*8 +: 8].
- out_data_1  out  8*X_MESH  single element; mesh i at [i*8 +: 8].
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- req  out  1  high while a line is in progress.
- idle  out  1  high when no line is active and the FSM is in ST_IDLE.

## Operation
- **Configuration.** `conf_input` in ST_IDLE latches all config inputs. `conf_input` outside ST_IDLE is ignored; registers keep their values.
- **Word count.** W = ceil(linelen/4) in both modes.
- **Mode A (pooled = 1).** Each word yields up to 4 beats, byte b at bits [8b +: 8]. The last word yields linelen − 4(W−1) beats.
- **Mode B (pooled = 0).** Each word yields up to 2 beats: bits [15:0] first, then [31:16]. The last word yields ceil((linelen − 4(W−1))/2) beats. Odd linelen: the final window still takes both bytes of its half.
- **Active columns.**
  - Mode A: column m = valid_mac.
  - Mode B: row 0 from m0 = valid_mac, row 1 from m1 = (valid_mac+1) mod 4. valid_mac = 3 therefore uses columns 3 and 0.
- **Read enables.** `enb` is high only for active columns, in all X_MESH rows.
- **Addresses.** `addrb` for every buffer (i,j) = st_addr lane j + word index w. Addition is modulo 2^ADDR_LEN (wrap, no error).
- **Output mapping.** Mode A: out_data_1 mesh i = byte b of doutb(i,m). Mode B: out_data_4 (i,r,k) = byte k of the selected half of doutb(i,m_r).
- **Unused output.** The bus for the inactive mode is driven 0.
- **FSM** (every transition is a clock edge):
  - ST_IDLE → ST_FETCH on an accepted config. If linelen = 0 it goes to ST_IDLE instead: `req` stays 0 and `enb` is never asserted.
  - ST_FETCH: `enb` high for exactly one cycle, `addrb` = start + w. Next state ST_WAIT.
  - ST_WAIT: count RD_LAT cycles. On the final count, capture doutb into a word register and go to ST_EMIT.
  - ST_EMIT: drive beats from the word register. The beat index advances on out_valid & out_ready. After the last beat of the word: go to ST_FETCH with w+1, or to ST_IDLE if w = W−1.
- **Reset mid-operation.** Return to ST_IDLE immediately. Abandon the line; in-flight BRAM data is discarded.

## Timing
- **Reset values.** addrb 0, enb 0, out_data_4 0, out_data_1 0, out_valid 0, req 0, idle 1.
- **Line start.** Config at cycle 0 → `enb` at cycle 1 → first out_valid at cycle 2+RD_LAT.
- **Cost per word.** 1 + RD_LAT + (number of beats) cycles with out_ready held high. Each stalled cycle adds one.
- **Backpressure.** While out_valid = 1 and out_ready = 0, the out_data_* outputs hold stable. No new read is issued while the current word still has unaccepted beats.
- **req** rises the cycle after config and falls the cycle after the last beat is accepted.
- **idle** = !req && state == ST_IDLE.

## Test plan
- Mode A, st_addr lane2 = 10, valid_mac = 2, linelen = 6, out_ready = 1; word@10 = 0x44332211, word@11 = 0x..6655 → enb only on column 2, at addresses 10 then 11; out_data_1 beats 11,22,33,44,55,66; req low after the 6th beat.
- Mode B, valid_mac = 3, linelen = 8, lanes 3/0 = 5/20 → enb on columns 3 and 0; 4 beats; beat 0 row 0 = low half of col3@5, row 1 = low half of col0@20.
- Mode B, linelen = 3 → 1 word, 2 beats; 2nd beat = high half.
- Backpressure: out_ready toggles 1,0,0,1 → data held during stalls, no beat lost or duplicated, no enb during a stall.
- linelen = 0 → no enb, req stays 0, idle back to 1 the next cycle.
- rst asserted in ST_WAIT → all outputs at reset values the next cycle; a new config then runs a clean line. conf_input during an active line → ignored, current line unaffected.
